regfile_sb: RTL and testbench

- Parametrised multi-port register file with byte-enable writes, optional hardwired-zero register 0, write-to-read bypass, and a per-register pending-write scoreboard.
- Sits in the CPU datapath between decode (read/reserve) and writeback (write/release).
- Generalises the 32x32 two-read-port file in width, depth and read-port count.
- Adds scoreboard state so issue logic can stall on registers with an outstanding write.

---
 rtl/regfile_sb.sv | 118 +++++++++++
 tb/tb_regfile_sb.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Multi-port register file with byte-enable writes, optional hardwired-zero
// register 0, write-to-read bypass and a per-register pending-write scoreboard.
// Decode reads and reserves destinations; writeback writes and releases them.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [DATA_W/8-1:0]        wr_be,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr,
    output logic [ADDR_W:0]            busy_cnt
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [ADDR_W:0]   cnt_q;
    logic [ADDR_W:0]   cnt_d;

    logic              wr_ok;
    logic              rsv_ok;
    logic [DATA_W-1:0] wr_merged;

    // A protected register 0 swallows both writes and reservations.
    assign wr_ok  = wr_en  && !((ZERO_REG != 0) && (wr_addr  == '0));
    assign rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

    // Stored value of the write target with the enabled bytes replaced.
    always_comb begin
        // NOTE: every variable written here gets a value on every path first, so no latch is inferred.
        wr_merged = mem_q[wr_addr];
        for (int b = 0; b < NB; b++) begin
            if (wr_be[b]) begin
                wr_merged[8*b +: 8] = wr_data[8*b +: 8];
            end
        end
    end

    // Register storage; writes land on the rising edge.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            // NOTE: the array is cleared by reset because software-visible state must read 0 after clr, which forces flops instead of a RAM macro.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_ok) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            mem_q[wr_addr] <= wr_merged;
        end
    end

    // Next scoreboard: write releases first, then a reservation sets, so a same-address reserve wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_ok) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (rsv_ok) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    // Population count of the next scoreboard so busy_cnt tracks busy_q exactly.
    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_d = cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
        end
    end

    // Scoreboard and counter registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_cnt = cnt_q;

    // Independent combinational read ports with optional same-cycle forwarding.
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        assign addr = rd_addr[p*ADDR_W +: ADDR_W];

        // Select stored, forwarded or hardwired-zero value for this port.
        always_comb begin
            rd_data[p*DATA_W +: DATA_W] = mem_q[addr];
            rd_busy[p]                  = busy_q[addr];
            if ((BYPASS != 0) && wr_ok && (addr == wr_addr)) begin
                rd_data[p*DATA_W +: DATA_W] = wr_merged;
                rd_busy[p]                  = rsv_ok && (rsv_addr == addr);
            end
            if ((ZERO_REG != 0) && (addr == '0)) begin
                rd_data[p*DATA_W +: DATA_W] = '0;
                rd_busy[p]                  = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Testbench for regfile_sb: two configurations driven in lockstep
// (A: ZERO_REG=1 BYPASS=1, B: ZERO_REG=0 BYPASS=0) against a behavioural model.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        clr;
    logic [9:0]  rd_addr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        rsv_en;
    logic [4:0]  rsv_addr;

    logic [63:0] rd_data_a, rd_data_b;
    logic [1:0]  rd_busy_a, rd_busy_b;
    logic [5:0]  busy_cnt_a, busy_cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state per configuration: index 0 = A, 1 = B.
    logic [31:0] m_mem  [2][32];
    bit   [31:0] m_busy [2];

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .clr(clr), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_cnt(busy_cnt_a));

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .clr(clr), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_cnt(busy_cnt_b));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic bit zero_cfg(input int c);
        return c == 0;
    endfunction

    function automatic bit write_hits(input int c, input int a);
        return wr_en && (int'(wr_addr) == a) && !(zero_cfg(c) && a == 0);
    endfunction

    function automatic logic [31:0] exp_data(input int c, input int a);
        if (zero_cfg(c) && a == 0) return 32'h0;
        if (c == 0 && write_hits(c, a)) return merge(m_mem[c][a], wr_data, wr_be);
        return m_mem[c][a];
    endfunction

    function automatic logic exp_busy(input int c, input int a);
        if (zero_cfg(c) && a == 0) return 1'b0;
        if (c == 0 && write_hits(c, a)) return rsv_en && int'(rsv_addr) == a;
        return m_busy[c][a];
    endfunction

    function automatic int model_cnt(input int c);
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_busy[c][i]);
        return n;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < 2; c++) begin
            m_busy[c] = '0;
            for (int i = 0; i < 32; i++) m_mem[c][i] = '0;
        end
    endtask

    // Architectural effect of one clock edge: write releases, reserve marks busy.
    task automatic model_edge();
        for (int c = 0; c < 2; c++) begin
            if (wr_en && !(zero_cfg(c) && wr_addr == 0)) begin
                m_mem[c][wr_addr]  = merge(m_mem[c][wr_addr], wr_data, wr_be);
                m_busy[c][wr_addr] = 1'b0;
            end
            if (rsv_en && !(zero_cfg(c) && rsv_addr == 0)) m_busy[c][rsv_addr] = 1'b1;
        end
    endtask

    task automatic check_reads(input string tag);
        for (int p = 0; p < 2; p++) begin
            int a = int'(rd_addr[p*5 +: 5]);
            check({tag, "_dA"}, 64'(rd_data_a[p*32 +: 32]), 64'(exp_data(0, a)));
            check({tag, "_bA"}, 64'(rd_busy_a[p]), 64'(exp_busy(0, a)));
            check({tag, "_dB"}, 64'(rd_data_b[p*32 +: 32]), 64'(exp_data(1, a)));
            check({tag, "_bB"}, 64'(rd_busy_b[p]), 64'(exp_busy(1, a)));
        end
    endtask

    task automatic check_cnt(input string tag);
        check({tag, "_cntA"}, 64'(busy_cnt_a), 64'(model_cnt(0)));
        check({tag, "_cntB"}, 64'(busy_cnt_b), 64'(model_cnt(1)));
    endtask

    // Inputs are set before the call; check comb reads, take the edge, check counts.
    task automatic step(input string tag);
        #2;
        check_reads(tag);
        @(posedge clk);
        model_edge();
        #1;
        check_cnt(tag);
    endtask

    task automatic idle();
        wr_en = 1'b0; rsv_en = 1'b0; wr_be = 4'h0; wr_data = '0; wr_addr = '0; rsv_addr = '0;
    endtask

    task automatic set_rd(input int a1, input int a0);
        rd_addr = {5'(a1), 5'(a0)};
    endtask

    task automatic do_write(input int a, input logic [31:0] d, input logic [3:0] be);
        idle();
        wr_en = 1'b1; wr_addr = 5'(a); wr_data = d; wr_be = be;
        step("wr");
    endtask

    task automatic do_rsv(input int a);
        idle();
        rsv_en = 1'b1; rsv_addr = 5'(a);
        step("rsv");
    endtask

    task automatic pulse_clr(input string tag);
        idle();
        clr = 1'b1;
        #1;
        model_clear();
        check_reads(tag);
        check_cnt(tag);
        clr = 1'b0;
        #1;
    endtask

    initial begin
        clr = 1'b1;
        idle();
        set_rd(0, 0);
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 32; i += 2) begin
            set_rd(i + 1, i);
            #1;
            check_reads("reset");
        end
        check_cnt("reset");
        clr = 1'b0;
        #1;

        // Asynchronous clear mid-sequence.
        do_write(7, 32'hDEADBEEF, 4'hF);
        do_rsv(9);
        idle();
        set_rd(9, 7);
        #1;
        check("pre_clr_r7", 64'(rd_data_a[31:0]), 64'h0000_0000_DEAD_BEEF);
        check("pre_clr_busy9", 64'(rd_busy_a[1]), 64'h1);
        pulse_clr("clr");
        check("clr_r7", 64'(rd_data_a[31:0]), 64'h0);
        check("clr_cnt", 64'(busy_cnt_a), 64'h0);

        // Byte-enable merge and register 0 protection.
        do_write(31, 32'h11223344, 4'hF);
        do_write(31, 32'hAABBCCDD, 4'b0101);
        do_write(0, 32'hFFFFFFFF, 4'hF);
        idle();
        set_rd(0, 31);
        #1;
        check_reads("be_r0");
        check("r31_merge", 64'(rd_data_a[31:0]), 64'h11BB33DD);
        check("r0_zero", 64'(rd_data_a[63:32]), 64'h0);
        check("r0_plain", 64'(rd_data_b[63:32]), 64'hFFFFFFFF);

        // Write-to-read bypass with both ports on r5.
        do_write(5, 32'h000000FF, 4'hF);
        idle();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h12345678; wr_be = 4'b1100;
        set_rd(5, 5);
        #1;
        check("byp_p0", 64'(rd_data_a[31:0]), 64'h123400FF);
        check("byp_p1", 64'(rd_data_a[63:32]), 64'h123400FF);
        check("nobyp_p0", 64'(rd_data_b[31:0]), 64'h000000FF);
        step("bypass");
        idle();
        #1;
        check("nobyp_after", 64'(rd_data_b[31:0]), 64'h123400FF);

        // Scoreboard reserve / release.
        do_rsv(3);
        do_rsv(4);
        do_rsv(3);
        idle();
        set_rd(4, 3);
        #1;
        check("cnt_two", 64'(busy_cnt_a), 64'h2);
        check("busy_r3", 64'(rd_busy_a[0]), 64'h1);
        do_write(3, 32'h0, 4'h0);
        idle();
        #1;
        check("cnt_one", 64'(busy_cnt_a), 64'h1);
        check("busy_r3_rel", 64'(rd_busy_a[0]), 64'h0);

        // Same-cycle reserve and write on a busy r12.
        do_rsv(12);
        idle();
        wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'hCAFEF00D; wr_be = 4'hF;
        rsv_en = 1'b1; rsv_addr = 5'd12;
        set_rd(12, 12);
        step("same12");
        idle();
        #1;
        check_reads("same12_after");
        check("r12_busy", 64'(rd_busy_a[0]), 64'h1);
        check("r12_data", 64'(rd_data_a[31:0]), 64'hCAFEF00D);
        check("r12_cnt", 64'(busy_cnt_a), 64'h2);

        // Fill the scoreboard, then try r0.
        for (int i = 1; i < 32; i++) do_rsv(i);
        do_rsv(0);
        idle();
        set_rd(1, 0);
        #1;
        check_reads("full");
        check("full_cntA", 64'(busy_cnt_a), 64'd31);
        check("full_cntB", 64'(busy_cnt_b), 64'd32);
        check("full_r0busy", 64'(rd_busy_a[0]), 64'h0);

        // Randomised traffic with occasional clears.
        pulse_clr("rclr0");
        for (int n = 0; n < 600; n++) begin
            logic [4:0] hot = 5'($urandom_range(0, 31));
            wr_en    = ($urandom_range(0, 3) != 0);
            rsv_en   = ($urandom_range(0, 2) != 0);
            wr_addr  = ($urandom_range(0, 3) == 0) ? hot : 5'($urandom);
            rsv_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
            wr_data  = $urandom;
            wr_be    = 4'($urandom);
            rd_addr  = {($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom),
                        ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom)};
            if ($urandom_range(0, 63) == 0) pulse_clr("rclr");
            else step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
